// File: rtl/iterative_divider.sv
// Multi-cycle restoring integer divider, one quotient bit per clock.
// Handles signed/unsigned operands, divide-by-zero and abort.
module iterative_divider #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             is_signed,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             ready,
    output logic             div_by_zero,
    output logic [CW-1:0]    count
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic             q_neg;
    logic             r_neg;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   shifted, trial;
    logic             fits;
    logic [WIDTH-1:0] rem_step, dvd_step;
    logic [WIDTH-1:0] q_final, r_final;
    logic             last_iter;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign last_iter = (count == CW'(1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (b == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The trial subtraction is one bit wider so its MSB acts as the borrow.
    always_comb begin
        a_neg    = is_signed & a[WIDTH-1];
        b_neg    = is_signed & b[WIDTH-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
        shifted  = {rem, dvd[WIDTH-1]};
        trial    = shifted - {1'b0, dvs};
        fits     = ~trial[WIDTH];
        rem_step = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        dvd_step = {dvd[WIDTH-2:0], fits};
        q_final  = q_neg ? -dvd_step : dvd_step;
        r_final  = r_neg ? -rem_step : rem_step;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rem         <= '0;
            dvd         <= '0;
            dvs         <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            count       <= '0;
            q           <= '0;
            r           <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (b != '0) begin
                            rem   <= '0;
                            dvd   <= a_mag;
                            dvs   <= b_mag;
                            q_neg <= a_neg ^ b_neg;
                            r_neg <= a_neg;
                            count <= CW'(WIDTH);
                        end else begin
                            q           <= '1;
                            r           <= a;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        count <= '0;
                    end else begin
                        rem   <= rem_step;
                        dvd   <= dvd_step;
                        count <= count - CW'(1);
                        if (last_iter) begin
                            q           <= q_final;
                            r           <= r_final;
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy  = (state == RUN);
    assign ready = (state == DONE);

endmodule

// File: doc/iterative_divider.md
# iterative_divider

Parametrised multi-cycle integer divider for the pipelined CPU's execute stage, alongside the FPU. It computes quotient and remainder of two WIDTH-bit operands in signed or unsigned mode using restoring division, one quotient bit per cycle. It uses a start/busy/ready handshake with an iteration counter. Generations before this one were fixed at 32-bit unsigned; this block adds width parametrisation, signed mode, divide-by-zero handling, and abort.

## Interface
- WIDTH, 32: operand and result width; legal range 4..64.
- CW, $clog2(WIDTH+1): width of `count` (derived; do not override).
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; one clock, asynchronous, active-high.
- start  in  1  request; sampled only while idle (`busy`=0).
- is_signed  in  1  1 = two's-complement operands; sampled with `start`.
- abort  in  1  cancels the operation in progress; returns to IDLE next edge.
- a  in  WIDTH  dividend; sampled with `start`.
- b  in  WIDTH  divisor; sampled with `start`.
- q  out  WIDTH  quotient; held until the next accepted `start`.
- r  out  WIDTH  remainder; held until the next accepted `start`.
- busy  out  1  operation in progress.
- ready  out  1  one-cycle pulse; `q`/`r` are valid.
- div_by_zero  out  1  result was produced with b==0; held with `q`/`r`.
- count  out  CW  iterations remaining.

## Operation
- States:
  - IDLE: accept `start`.
  - RUN: iterate.
  - DONE: single cycle; `ready`=1.
- IDLE→RUN: `start`=1 and b≠0.
  - Latch the magnitudes of a and b. In signed mode, negate when the MSB is set; otherwise use the raw value.
  - Latch the quotient sign (a[MSB]^b[MSB]) and remainder sign (a[MSB]), both gated by `is_signed`.
  - Set `count`=WIDTH; clear the partial remainder to 0.
- IDLE→DONE: `start`=1 and b==0. No iteration.
  - `q` = all ones.
  - `r` = a.
  - `div_by_zero` = 1.
- Each RUN cycle:
  - Shift {rem, dividend} left by one.
  - If the trial rem−divisor (WIDTH+1 bits) is non-negative, keep the difference and shift in quotient bit 1; else shift in 0.
  - Decrement `count`.
- RUN→DONE on the edge where `count` goes 1→0. On that edge:
  - Write the sign-corrected results to `q`/`r`.
  - The quotient is negated if its sign is set; the remainder is negated if its sign is set.
  - Division truncates toward zero.
- DONE→IDLE unconditionally on the next edge.
- Signed overflow (most-negative ÷ −1): `q` = most-negative value, `r` = 0. No flag is raised; this falls out of the magnitude arithmetic.
- `start` while `busy`=1 or in DONE: ignored, no effect.
- `abort` in RUN:
  - Next state is IDLE; `count` = 0.
  - `q`/`r`/`div_by_zero` keep their previous values.
  - No `ready` pulse.
- `abort` in IDLE or DONE: no effect. If `abort` and `start` are both high in IDLE, `start` wins.
- Output registers:
  - `q`/`r`/`div_by_zero` change only on the edge entering DONE.
  - `div_by_zero` clears when a nonzero-divisor result is written.

## Timing
- Reset values: `q`=0, `r`=0, `busy`=0, `ready`=0, `div_by_zero`=0, `count`=0; state IDLE.
- RST asserted mid-operation aborts immediately, with no `ready` pulse.
- `busy` = 1 exactly in RUN.
- `ready` = 1 exactly in DONE.
- Sequence for b≠0, with `start` accepted at edge E0:
  - `busy` high from E0 to E_WIDTH.
  - `ready` high from E_WIDTH to E_WIDTH+1.
  - Latency: WIDTH+1 cycles from the `start` edge to `ready` falling.
- Sequence for b==0: `ready` high from E0 to E1; `busy` never asserts.
- Back-to-back: the next `start` is accepted at E_WIDTH+1 (the first IDLE cycle).
- `q`/`r` are registered outputs. No combinational path runs from the inputs to any output.

## Test plan
- Unsigned, WIDTH=32: a=3248576, b=2038, is_signed=0 -> `ready` on the 32nd edge after `start`; q=1594, r=4; `count` steps 32→0.
- Signed, WIDTH=32: a=−7 (0xFFFFFFF9), b=2 -> q=0xFFFFFFFD (−3), r=0xFFFFFFFF (−1). Also a=7, b=−2 -> q=−3, r=1.
- Divide by zero: a=0x1234, b=0 -> `ready` 1 cycle after `start`; q=0xFFFFFFFF, r=0x1234, div_by_zero=1. A following 10/3 clears `div_by_zero` (q=3, r=1).
- Overflow and start masking:
  - a=0x80000000, b=0xFFFFFFFF, signed -> q=0x80000000, r=0.
  - A second `start` pulsed mid-RUN is ignored, and the result is unchanged.
- Abort and reset:
  - `abort` at count=10 -> IDLE next cycle, no `ready`, prior q/r retained.
  - RST at count=5 -> all outputs 0 immediately.
- WIDTH=8 instance: a=200, b=7 unsigned -> q=28, r=4 after 8 iterations. Signed a=0x80, b=0xFF -> q=0x80, r=0.
